i2s_tx_fifo_engine: RTL
=======================

Name: i2s_tx_fifo_engine

Overview:
- Parametrised stereo I2S transmitter (bus slave: external BCLK/LRCLK) with an input sample FIFO and valid/ready handshake.
- Sits between the audio synthesis path and the codec DAC pin.
- Generalises the fixed 24-bit/64-fs serialiser with:
  - selectable sample width and slot width;
  - I2S or left-justified framing;
  - mute;
  - underrun detection;
  - FIFO-level reporting.

Parameters:
- DATA_W, 24, sample width per channel (8..SLOT_W).
- SLOT_W, 32, BCLK periods per channel slot (16..32).
- FIFO_DEPTH, 4, stereo-sample FIFO entries (power of 2, >=2).
- SYNC_STAGES, 2, synchroniser flops on i2s_bclk and i2s_lr (>=2).

Ports:
- clk  in  1  system clock; must be >= 8x BCLK.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = I2S (one-BCLK MSB delay), 1 = left-justified; sampled at left-slot start only.
- mute  in  1  1 = transmit zeros; sampled at left-slot start only.
- s_valid  in  1  sample-pair valid.
- s_ready  out  1  FIFO not full.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
- i2s_bclk  in  1  codec bit clock (asynchronous).
- i2s_lr  in  1  codec word clock: 0 = left, 1 = right.
- i2s_d_out  out  1  serial data.

Behaviour:
- Reset (rst=0, async): FIFO empty, fifo_level=0, s_ready=1, underrun=0, i2s_d_out=0, shift/holding registers 0, lr_last=1, delay flop 0.
- Synchroniser and edge detect:
  - i2s_bclk and i2s_lr pass through SYNC_STAGES flops.
  - A BCLK falling-edge event (fe) is a one-clk strobe when the synced bclk goes 1 -> 0.
  - All serial-side logic advances only on fe.
- FIFO:
  - Push when s_valid & s_ready.
  - Pop only on a left-slot start with the FIFO non-empty.
  - Push and pop in the same clk: level unchanged; push permitted while full-with-pop, but s_ready stays registered-from-level (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- Slot starts, evaluated on fe, comparing synced lr with lr_last (lr_last updated on every fe):
  - lr 1->0 (LEFT_START):
    - mode and mute are latched.
    - If the FIFO is empty: holding pair <= 0 and underrun pulses for 1 clk.
    - Otherwise: pop into holding.
    - Shift register <= {left, (SLOT_W-DATA_W) zeros}.
  - lr 0->1 (RIGHT_START): shift register <= {right, zeros}.
  - Otherwise: shift left by 1, filling with 0.
  - After SLOT_W shifts, output stays 0 until the next slot start. A short slot (LR toggles early) truncates the data; no error is flagged.
- Output, updated on fe only:
  - Left-justified: i2s_d_out <= MSB of the value just loaded or shifted.
  - I2S: i2s_d_out <= delay flop; delay flop <= that same MSB. The MSB of each channel therefore appears one BCLK after the LR edge, and the previous slot's LSB occupies the first bit of the next slot.
  - Muted frame: i2s_d_out forced 0 for both slots; the FIFO is still popped.
- Latency:
  - Push to first transmitted bit = next LEFT_START, plus SYNC_STAGES+1 clk, plus the I2S delay when mode=0.
  - An empty FIFO at LEFT_START yields a zero frame even if a push occurs in the same clk.
- Reset mid-frame clears everything; transmission restarts at the next LR falling edge. The first fe after reset with lr=0 does not count as LEFT_START, because lr_last resets to 1 but must first observe 1.

Decomposition:
- Shared package i2s_pkg:
  - MODE_I2S / MODE_LJ constants;
  - LR_LEFT / LR_RIGHT constants;
  - a function computing the fifo_level width.
- One sub-module, i2s_sample_fifo: parametrised DATA_W*2 x FIFO_DEPTH synchronous FIFO with level, full and empty outputs.
- Edge detection and serialiser stay in the top level.

Test Plan:
- LJ, DATA_W=24, SLOT_W=32: push L=24'hA5A5A5, R=24'h00000F → left slot bits 1010...0101 followed by 8 zeros. Right slot: 20 zeros, 1111, 8 zeros. MSB on the first fe after the LR edge.
- I2S mode, same data → identical bit stream delayed by exactly one BCLK relative to LR edges; the first bit of the left slot equals the previous right LSB (0).
- Underrun: run frames with no pushes → i2s_d_out constant 0 and exactly one underrun pulse per frame. Push one pair mid-frame → transmitted at the next LEFT_START, underrun stops.
- FIFO full: push 5 pairs with FIFO_DEPTH=4 without a frame start → s_ready=0 after 4 and fifo_level=4. At LEFT_START, level=3 and s_ready=1 on the next clk.
- Mute asserted mid-left-slot → current frame unaffected; the next frame outputs zeros while fifo_level still decrements by 1.
- Async reset asserted mid-right-slot → i2s_d_out=0 and fifo_level=0 immediately. After release, the first data appears only after an LR 1->0 transition.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit engine.
package i2s_pkg;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_LEFT,
        SLOT_RIGHT
    } slot_ev_e;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO: WIDTH x DEPTH, registered level with full/empty flags.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                wdata,
    input  logic                            pop,
    output logic [WIDTH-1:0]                rdata,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic                            full,
    output logic                            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i2s_tx_fifo_engine.sv
// Stereo I2S / left-justified transmitter, bus slave to external BCLK/LRCLK,
// fed from a sample FIFO with valid/ready handshake.
module i2s_tx_fifo_engine
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned SLOT_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mode,
    input  logic                                  mute,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_W-1:0]                     s_left,
    input  logic [DATA_W-1:0]                     s_right,
    output logic [level_width(FIFO_DEPTH)-1:0]    fifo_level,
    output logic                                  underrun,
    input  logic                                  i2s_bclk,
    input  logic                                  i2s_lr,
    output logic                                  i2s_d_out
);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   bclk_s;
    logic                   lr_s;
    logic                   bclk_d;
    logic                   fe;
    logic                   lr_last;
    logic                   lr_armed;
    slot_ev_e               slot_ev;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [2*DATA_W-1:0]    fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic [SLOT_W-1:0]      shift_q, shift_n;
    logic [DATA_W-1:0]      hold_q, hold_n;
    logic                   mode_q, mode_n;
    logic                   mute_q, mute_n;
    logic                   delay_q;
    logic                   tx_bit;

    function automatic logic [SLOT_W-1:0] slot_align(input logic [DATA_W-1:0] s);
        logic [SLOT_W-1:0] v;
        v = '0;
        v[SLOT_W-1 -: DATA_W] = s;
        return v;
    endfunction

    assign bclk_s = bclk_sync[SYNC_STAGES-1];
    assign lr_s   = lr_sync[SYNC_STAGES-1];
    assign fe     = bclk_d & ~bclk_s;

    // LEFT_START needs lr_last to have genuinely seen the right slot since
    // reset; the reset value of lr_last alone does not qualify.
    always_comb begin
        slot_ev = SLOT_NONE;
        if (fe) begin
            if (lr_armed && lr_last == LR_RIGHT && lr_s == LR_LEFT)
                slot_ev = SLOT_LEFT;
            else if (lr_last == LR_LEFT && lr_s == LR_RIGHT)
                slot_ev = SLOT_RIGHT;
        end
    end

    assign s_ready   = ~fifo_full;
    assign fifo_push = s_valid & s_ready;
    assign fifo_pop  = (slot_ev == SLOT_LEFT);

    i2s_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({s_left, s_right}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        shift_n = {shift_q[SLOT_W-2:0], 1'b0};
        hold_n  = hold_q;
        mode_n  = mode_q;
        mute_n  = mute_q;
        case (slot_ev)
            SLOT_LEFT: begin
                mode_n  = mode;
                mute_n  = mute;
                hold_n  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
                shift_n = slot_align(fifo_empty ? '0 : fifo_rdata[2*DATA_W-1:DATA_W]);
            end
            SLOT_RIGHT: shift_n = slot_align(hold_q);
            default:    ;
        endcase
        tx_bit = shift_n[SLOT_W-1] & ~mute_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            bclk_d    <= 1'b0;
            lr_last   <= LR_RIGHT;
            lr_armed  <= 1'b0;
            shift_q   <= '0;
            hold_q    <= '0;
            mode_q    <= MODE_I2S;
            mute_q    <= 1'b0;
            delay_q   <= 1'b0;
            i2s_d_out <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lr};
            bclk_d    <= bclk_s;
            underrun  <= (slot_ev == SLOT_LEFT) && fifo_empty;
            if (fe) begin
                lr_last <= lr_s;
                if (lr_s == LR_RIGHT) lr_armed <= 1'b1;
                shift_q <= shift_n;
                hold_q  <= hold_n;
                mode_q  <= mode_n;
                mute_q  <= mute_n;
                delay_q <= tx_bit;
                i2s_d_out <= (mode_n == MODE_LJ) ? tx_bit : (delay_q & ~mute_n);
            end
        end
    end

endmodule
